// File: rtl/m_axi_mem_sched.sv
// m_axi_mem_sched: job scheduler in front of the AXI memory mover engine.
// Buffers transfer descriptors in a small FIFO. Issues them to the engine one
// at a time with a single-cycle start. Waits for the engine's done level and
// retires each job. A watchdog parks the block in HALT if the engine hangs.
//
// state  | meaning
// -------+-------------------------------------------------------------------
// IDLE   | nothing in flight; pops the queue head into the descriptor outputs
// LOAD   | descriptor already on engine ports; zero-byte jobs bypass engine
// START  | O_ap_start high for this one cycle; watchdog cleared
// CLR    | wait for the engine to drop the done level left by the last job
// BUSY   | engine running; wait for done
// DONE   | retire pulse (err qualifies it), count error-free jobs
// HALT   | watchdog fired; queue frozen, no starts, left only through I_rst
module m_axi_mem_sched #(
    parameter int C_JOB_DEPTH = 4,
    parameter int C_TIMEOUT_W = 24,
    parameter int C_CNT_W     = 16
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_job_valid,
    output logic                          O_job_ready,
    input  logic [31:0]                   I_job_rd_addr,
    input  logic [31:0]                   I_job_wr_addr,
    input  logic [31:0]                   I_job_in_bytes,
    input  logic [31:0]                   I_job_out_bytes,
    input  logic [C_TIMEOUT_W-1:0]        I_timeout_cycles,
    output logic                          O_ap_start,
    output logic [31:0]                   O_ddr_rd_addr,
    output logic [31:0]                   O_ddr_wr_addr,
    output logic [31:0]                   O_in_data_bytes,
    output logic [31:0]                   O_out_data_bytes,
    input  logic                          I_ap_done,
    output logic                          O_busy,
    output logic                          O_job_done,
    output logic                          O_job_err,
    output logic [C_CNT_W-1:0]            O_job_cnt,
    output logic                          O_err_timeout,
    output logic [$clog2(C_JOB_DEPTH):0]  O_queue_level
);

    localparam int C_PTR_W = $clog2(C_JOB_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_CLR   = 3'd3,
        S_BUSY  = 3'd4,
        S_DONE  = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [127:0]           r_mem [C_JOB_DEPTH];
    logic [C_PTR_W-1:0]     r_wr_ptr;
    logic [C_PTR_W-1:0]     r_rd_ptr;
    logic [C_PTR_W:0]       r_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;

    logic [31:0]            r_ddr_rd_addr;
    logic [31:0]            r_ddr_wr_addr;
    logic [31:0]            r_in_bytes;
    logic [31:0]            r_out_bytes;
    logic                   w_zero_job;
    logic                   r_err;

    logic [C_TIMEOUT_W-1:0] r_wdog_cnt;
    logic [C_TIMEOUT_W-1:0] w_wdog_nxt;
    logic                   w_wdog_run;
    logic                   w_wdog_fire;

    logic [C_CNT_W-1:0]     r_job_cnt;
    logic                   r_err_timeout;

    assign w_full      = (r_level == (C_PTR_W+1)'(C_JOB_DEPTH));
    assign w_empty     = (r_level == '0);
    assign O_job_ready = !w_full && (r_state != S_HALT) && !I_rst;
    assign w_push      = I_job_valid && O_job_ready;
    assign w_zero_job  = (r_in_bytes == '0) || (r_out_bytes == '0);

    // The watchdog compare uses the count including the current cycle, so a
    // limit of N halts after exactly N cycles spent in CLR/BUSY.
    assign w_wdog_run  = (r_state == S_CLR) || (r_state == S_BUSY);
    assign w_wdog_nxt  = (&r_wdog_cnt) ? r_wdog_cnt : r_wdog_cnt + 1'b1;
    assign w_wdog_fire = w_wdog_run && (I_timeout_cycles != '0) &&
                         (w_wdog_nxt == I_timeout_cycles);

    assign O_ddr_rd_addr    = r_ddr_rd_addr;
    assign O_ddr_wr_addr    = r_ddr_wr_addr;
    assign O_in_data_bytes  = r_in_bytes;
    assign O_out_data_bytes = r_out_bytes;
    assign O_job_cnt        = r_job_cnt;
    assign O_err_timeout    = r_err_timeout;
    assign O_queue_level    = r_level;

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the watchdog outranks a done seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_zero_job ? S_DONE : S_START;
            S_START: w_state_nxt = S_CLR;
            S_CLR: begin
                if (w_wdog_fire)     w_state_nxt = S_HALT;
                else if (!I_ap_done) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (w_wdog_fire)     w_state_nxt = S_HALT;
                else if (I_ap_done)  w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs plus the queue pop strobe.
    always_comb begin
        O_ap_start = (r_state == S_START);
        O_busy     = (r_state != S_IDLE);
        O_job_done = (r_state == S_DONE);
        O_job_err  = (r_state == S_DONE) && r_err;
        w_pop      = (r_state == S_IDLE) && !w_empty;
    end

    // Queue pointers and level; simultaneous push and pop leave the level alone.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Queue storage; contents are don't-care until written.
    always_ff @(posedge I_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {I_job_rd_addr, I_job_wr_addr,
                                I_job_in_bytes, I_job_out_bytes};
        end
    end

    // Descriptor outputs move only on a pop, so they hold through the engine's start sample.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_ddr_rd_addr <= '0;
            r_ddr_wr_addr <= '0;
            r_in_bytes    <= '0;
            r_out_bytes   <= '0;
        end else if (w_pop) begin
            {r_ddr_rd_addr, r_ddr_wr_addr, r_in_bytes, r_out_bytes} <= r_mem[r_rd_ptr];
        end
    end

    // Skip flag: set in LOAD for zero-byte jobs, consumed by DONE.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_err <= w_zero_job;
        end else if (r_state == S_DONE) begin
            r_err <= 1'b0;
        end
    end

    // Watchdog: cleared at start, saturating count while waiting on the engine.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_START) begin
            r_wdog_cnt <= '0;
        end else if (w_wdog_run) begin
            r_wdog_cnt <= w_wdog_nxt;
        end
    end

    // Completed-job counter and sticky timeout flag.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_job_cnt     <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if ((r_state == S_DONE) && !r_err) r_job_cnt <= r_job_cnt + 1'b1;
            if (w_wdog_fire)                   r_err_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/m_axi_mem_sched.md
# m_axi_mem_sched

Job scheduler in front of the AXI memory mover engine. It buffers up to C_JOB_DEPTH transfer descriptors (read address, write address, input byte count, output byte count) and issues them to the engine one at a time. For each job it drives the engine's start handshake, waits for completion and reports it. A watchdog guards against a hung engine. It sits between the host/control logic and the engine's I_ap_start / I_ddr_* / I_*_data_bytes / O_ap_done ports.

## Interface
- C_JOB_DEPTH, 4: descriptor queue depth; power of two, ≥2.
- C_TIMEOUT_W, 24: watchdog counter width.
- C_CNT_W, 16: completed-job counter width.
- Clocking: one clock, I_clk. Reset I_rst is synchronous and active-high.
- I_clk  in  1  clock.
- I_rst  in  1  synchronous active-high reset.
- I_job_valid  in  1  descriptor offered.
- O_job_ready  out  1  descriptor accepted when valid&ready.
- I_job_rd_addr  in  32  engine read base address.
- I_job_wr_addr  in  32  engine write base address.
- I_job_in_bytes  in  32  bytes to read.
- I_job_out_bytes  in  32  bytes to write.
- I_timeout_cycles  in  C_TIMEOUT_W  watchdog limit; 0 disables.
- O_ap_start  out  1  to engine I_ap_start.
- O_ddr_rd_addr  out  32  to engine.
- O_ddr_wr_addr  out  32  to engine.
- O_in_data_bytes  out  32  to engine.
- O_out_data_bytes  out  32  to engine.
- I_ap_done  in  1  from engine O_ap_done; a level that the engine clears after it samples a start.
- O_busy  out  1  state ≠ IDLE.
- O_job_done  out  1  one-cycle pulse per retired job.
- O_job_err  out  1  qualifies O_job_done: job was skipped.
- O_job_cnt  out  C_CNT_W  jobs completed without error; wraps.
- O_err_timeout  out  1  sticky watchdog error.
- O_queue_level  out  log2(C_JOB_DEPTH)+1  queued descriptors.

## Operation
- Queue: 128-bit FIFO.
  - O_job_ready = !full && state≠HALT && !I_rst.
  - A push and a pop in the same cycle are both honoured. The level is unchanged.
- FSM states:
  - IDLE: if the queue is not empty, pop the head into the output registers and go to LOAD. Otherwise stay in IDLE.
  - LOAD: if either the in or out byte count is 0, go to DONE with the err flag set. Otherwise go to START.
  - START: O_ap_start=1 for exactly this cycle. Clear the watchdog. Go to CLR.
  - CLR: wait until I_ap_done==0, which is the engine's stale done clearing, then go to BUSY.
  - BUSY: when I_ap_done==1, go to DONE.
  - DONE:
    - Pulse O_job_done and drive O_job_err from the err flag.
    - If err=0, increment O_job_cnt.
    - Clear err. Go to IDLE.
  - HALT: entered from CLR or BUSY when the watchdog fires.
    - Set O_err_timeout.
    - O_ap_start stays 0 and the queue is frozen.
    - Only I_rst exits HALT.
- Watchdog:
  - Counts cycles spent in CLR and BUSY.
  - Fires when the count equals I_timeout_cycles and I_timeout_cycles≠0.
  - The count saturates and does not wrap.
- Descriptor outputs (O_ddr_*, O_*_data_bytes):
  - They change only on the IDLE→LOAD edge.
  - They are stable from LOAD until the next pop, which covers the engine's start-edge sample.

## Timing
- Reset values: all outputs 0; queue empty; state IDLE; O_err_timeout 0; O_job_cnt 0.
- Push to start latency, with an idle scheduler and empty queue:
  - Push accepted in cycle 0.
  - IDLE pops in cycle 1.
  - LOAD in cycle 2.
  - O_ap_start=1 in cycle 3.
- Completion:
  - I_ap_done is first seen high in BUSY in cycle d.
  - O_job_done=1 in cycle d+1.
  - IDLE in cycle d+2.
  - The next job's O_ap_start is in cycle d+4.
- O_ap_start is low for at least 3 cycles between jobs, which guarantees a fresh rising edge at the engine.
- If I_ap_done is already 0 when CLR is entered, CLR lasts 1 cycle.
- Zero-byte job: pop to O_job_done takes 2 cycles (LOAD, DONE). No O_ap_start is issued.
- Reset mid-job:
  - The queue is flushed and the state goes to IDLE.
  - The in-flight engine transfer is not tracked; the engine must be reset or drained by the system.
- O_queue_level updates the cycle after a push or pop.

## Test plan
- Single job (rd 0x1000, wr 0x8000, 256 B in, 256 B out), engine model asserts done 40 cycles after start:
  - O_ap_start high only in cycle 3.
  - Descriptor outputs are 0x1000/0x8000/256/256 in cycle 3.
  - O_job_done=1 with O_job_err=0.
  - O_job_cnt=1.
- Five back-to-back jobs with C_JOB_DEPTH=4 and engine busy:
  - O_job_ready drops when the level is 4.
  - The fifth push waits until the first pop.
  - Jobs start in push order.
  - O_job_cnt=5 at the end.
- Stale done: I_ap_done held high for 2 cycles after start:
  - The FSM stays in CLR for 2 cycles.
  - It does not retire the job early.
  - Exactly one O_job_done.
- Zero-byte job (in_bytes=0) between two valid jobs:
  - O_job_done with O_job_err=1.
  - No start pulse for it.
  - O_job_cnt=2.
- Watchdog with I_timeout_cycles=100 and I_ap_done never rising:
  - O_err_timeout=1 100 cycles after CLR entry.
  - O_job_ready=0 and O_ap_start stays 0.
  - I_rst clears everything to reset values.
- I_rst pulsed while 3 jobs are queued and one is BUSY:
  - O_queue_level=0 and O_busy=0 next cycle.
  - No O_job_done is produced for the dropped jobs.
